accel_loader: RTL

ACCEL_LOADER -- requirements
Module: accel_loader

---
 rtl/accel_loader.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/accel_loader.sv
// Wishbone loader for a matrix accelerator: writes the job configuration and operands A and B,
// starts the engine, then reads result C back out on a ready/valid stream.
module accel_loader #(
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic        wishbone_clk_i,
    input  logic        wishbone_rst_i,
    input  logic        start,
    input  logic [31:0] cfg_op,
    input  logic [14:0] cfg_w_a,
    input  logic [14:0] cfg_h_a,
    input  logic [14:0] cfg_w_b,
    input  logic [14:0] cfg_h_b,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic [31:0] wbm_addr_o,
    output logic [31:0] wbm_data_o,
    output logic        wbm_we_o,
    output logic        wbm_stb_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_data_i,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, CFG, LOAD_A, LOAD_B, GO, READ_C} state_t;

    localparam logic [31:0] TMO_LAST = 32'(ACK_TIMEOUT - 1);

    state_t      state_q;
    logic [31:0] op_q;
    logic [14:0] wA_q, hA_q, wB_q, hB_q;
    logic [14:0] i_q, j_q;
    logic [2:0]  cfgIdx_q;
    logic [31:0] tmoCnt_q;
    logic        stb_q, we_q, mValid_q, done_q, err_q;
    logic [31:0] addr_q, wData_q, mData_q;

    logic [14:0] curW, curH;
    logic [31:0] cfgWord;
    logic        lastCol, lastElem;

    // Matrix geometry walked by the i/j counters in the current phase.
    always_comb begin
        curW = wB_q;
        curH = hA_q;
        case (state_q)
            LOAD_A:  begin curW = wA_q; curH = hA_q; end
            LOAD_B:  begin curW = wB_q; curH = hB_q; end
            default: ;
        endcase
    end

    assign lastCol  = (j_q == curW - 15'd1);
    assign lastElem = lastCol && (i_q == curH - 15'd1);

    always_comb begin
        cfgWord = op_q;
        case (cfgIdx_q)
            3'd1:    cfgWord = {17'd0, wA_q};
            3'd2:    cfgWord = {17'd0, hA_q};
            3'd3:    cfgWord = {17'd0, wB_q};
            3'd4:    cfgWord = {17'd0, hB_q};
            default: ;
        endcase
    end

    assign wbm_stb_o  = stb_q;
    assign wbm_we_o   = we_q;
    assign wbm_addr_o = addr_q;
    assign wbm_data_o = wData_q;
    assign m_valid    = mValid_q;
    assign m_data     = mData_q;
    assign done       = done_q;
    assign err        = err_q;
    assign busy       = (state_q != IDLE);
    assign s_ready    = ((state_q == LOAD_A) || (state_q == LOAD_B)) && !stb_q;

    // A new strobe is only raised from a cycle where stb is low, which guarantees the idle gap.
    always_ff @(posedge wishbone_clk_i) begin
        if (wishbone_rst_i) begin
            state_q  <= IDLE;
            op_q     <= '0;
            wA_q     <= '0;
            hA_q     <= '0;
            wB_q     <= '0;
            hB_q     <= '0;
            i_q      <= '0;
            j_q      <= '0;
            cfgIdx_q <= '0;
            tmoCnt_q <= '0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            mValid_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wData_q  <= '0;
            mData_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (stb_q) begin
                if (wbm_ack_i) begin
                    stb_q <= 1'b0;
                    case (state_q)
                        CFG: begin
                            if (cfgIdx_q == 3'd4) begin
                                state_q <= LOAD_A;
                                i_q     <= '0;
                                j_q     <= '0;
                            end else begin
                                cfgIdx_q <= cfgIdx_q + 3'd1;
                            end
                        end
                        LOAD_A, LOAD_B: begin
                            if (lastElem) begin
                                state_q <= (state_q == LOAD_A) ? LOAD_B : GO;
                                i_q     <= '0;
                                j_q     <= '0;
                            end else if (lastCol) begin
                                j_q <= '0;
                                i_q <= i_q + 15'd1;
                            end else begin
                                j_q <= j_q + 15'd1;
                            end
                        end
                        GO: begin
                            state_q <= READ_C;
                            i_q     <= '0;
                            j_q     <= '0;
                        end
                        READ_C: begin
                            mData_q  <= wbm_data_i;
                            mValid_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end else if (tmoCnt_q == TMO_LAST) begin
                    stb_q   <= 1'b0;
                    err_q   <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end else begin
                    tmoCnt_q <= tmoCnt_q + 32'd1;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            if ((cfg_w_a != '0) && (cfg_h_a != '0) && (cfg_w_b != '0) && (cfg_h_b != '0)) begin
                                op_q     <= cfg_op;
                                wA_q     <= cfg_w_a;
                                hA_q     <= cfg_h_a;
                                wB_q     <= cfg_w_b;
                                hB_q     <= cfg_h_b;
                                err_q    <= 1'b0;
                                cfgIdx_q <= '0;
                                state_q  <= CFG;
                            end else begin
                                err_q  <= 1'b1;
                                done_q <= 1'b1;
                            end
                        end
                    end
                    CFG: begin
                        stb_q    <= 1'b1;
                        we_q     <= 1'b1;
                        addr_q   <= {29'd0, cfgIdx_q};
                        wData_q  <= cfgWord;
                        tmoCnt_q <= '0;
                    end
                    LOAD_A, LOAD_B: begin
                        if (s_valid) begin
                            stb_q    <= 1'b1;
                            we_q     <= 1'b1;
                            addr_q   <= {(state_q == LOAD_A) ? 2'b01 : 2'b10, i_q, j_q};
                            wData_q  <= s_data;
                            tmoCnt_q <= '0;
                        end
                    end
                    GO: begin
                        stb_q    <= 1'b1;
                        we_q     <= 1'b1;
                        addr_q   <= 32'd5;
                        wData_q  <= 32'hFFFF_FFFF;
                        tmoCnt_q <= '0;
                    end
                    READ_C: begin
                        // The next read waits until the previous result has left the output register.
                        if (mValid_q) begin
                            if (m_ready) begin
                                mValid_q <= 1'b0;
                                if (lastElem) begin
                                    done_q  <= 1'b1;
                                    state_q <= IDLE;
                                end else if (lastCol) begin
                                    j_q <= '0;
                                    i_q <= i_q + 15'd1;
                                end else begin
                                    j_q <= j_q + 15'd1;
                                end
                            end
                        end else begin
                            stb_q    <= 1'b1;
                            we_q     <= 1'b0;
                            addr_q   <= {2'b11, i_q, j_q};
                            wData_q  <= '0;
                            tmoCnt_q <= '0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule
